// File: rtl/display_0_99.sv
`default_nettype none
// ============================================================================
// Module      : display_0_99
// Description : Two-digit multiplexed 7-segment driver for a 00..99 BCD value
//               with leading-zero blanking and whole-display blink.
// Revision    : 1.0 - initial release
// ============================================================================
module display_0_99 #(
    parameter int DIV       = 50000,
    parameter int BLINK_DIV = 250
) (
    input  logic clock,
    input  logic reset,
    input  logic M3,
    input  logic M2,
    input  logic M1,
    input  logic M0,
    input  logic S3,
    input  logic S2,
    input  logic S1,
    input  logic S0,
    input  logic blank_zero,
    input  logic blink,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic e,
    output logic f,
    output logic g,
    output logic D1,
    output logic D0
);

    localparam int c_presc_w = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int c_bcnt_w  = $clog2(BLINK_DIV + 1);

    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(DIV - 1);
    localparam logic [c_bcnt_w-1:0]  c_bcnt_max  = c_bcnt_w'(BLINK_DIV - 1);

    localparam logic [0:0] c_st_uni = 1'b0;
    localparam logic [0:0] c_st_dez = 1'b1;

    localparam logic [6:0] c_seg_blank = 7'b111_1111;
    localparam logic [6:0] c_seg_dash  = 7'b111_1110;
    localparam logic [1:0] c_dig_off   = 2'b11;
    localparam logic [1:0] c_dig_tens  = 2'b01;
    localparam logic [1:0] c_dig_units = 2'b10;

    logic [c_presc_w-1:0] r_presc;
    logic [c_bcnt_w-1:0]  r_bcnt;
    logic                 r_phase;
    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [7:0]           r_snap;
    logic                 r_upd;
    logic [6:0]           r_seg;
    logic [1:0]           r_dig;

    logic                 w_tick;
    logic [3:0]           w_digit;
    logic [6:0]           w_seg_code;
    logic                 w_blank;
    logic [6:0]           w_seg_nxt;
    logic [1:0]           w_dig_nxt;

    assign w_tick = (r_presc == c_presc_max);

    // Prescaler producing the scan tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Blink timebase runs on scan ticks whether or not blink is requested
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_bcnt == c_bcnt_max) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    // Scan FSM: state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_uni;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scan FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_tick) begin
            case (r_state)
                c_st_uni: w_state_nxt = c_st_dez;
                c_st_dez: w_state_nxt = c_st_uni;
                default:  w_state_nxt = c_st_uni;
            endcase
        end
    end

    // Sampling only at frame start keeps both digits of a frame coherent
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snap <= 8'h00;
        end else if (w_tick && (r_state == c_st_dez)) begin
            r_snap <= {S3, S2, S1, S0, M3, M2, M1, M0};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_upd <= 1'b0;
        end else begin
            r_upd <= w_tick;
        end
    end

    assign w_digit = (r_state == c_st_dez) ? r_snap[7:4] : r_snap[3:0];

    // Active-low segment pattern, bit order {a,b,c,d,e,f,g}
    always_comb begin
        w_seg_code = c_seg_dash;
        case (w_digit)
            4'd0:    w_seg_code = 7'b000_0001;
            4'd1:    w_seg_code = 7'b100_1111;
            4'd2:    w_seg_code = 7'b001_0010;
            4'd3:    w_seg_code = 7'b000_0110;
            4'd4:    w_seg_code = 7'b100_1100;
            4'd5:    w_seg_code = 7'b010_0100;
            4'd6:    w_seg_code = 7'b010_0000;
            4'd7:    w_seg_code = 7'b000_1111;
            4'd8:    w_seg_code = 7'b000_0000;
            4'd9:    w_seg_code = 7'b000_0100;
            default: w_seg_code = c_seg_dash;
        endcase
    end

    // Scan FSM: output logic
    always_comb begin
        w_blank   = 1'b0;
        w_seg_nxt = w_seg_code;
        w_dig_nxt = c_dig_units;
        if (blink && !r_phase) begin
            w_blank = 1'b1;
        end
        if ((r_state == c_st_dez) && blank_zero && (r_snap[7:4] == 4'd0)) begin
            w_blank = 1'b1;
        end
        if (r_state == c_st_dez) begin
            w_dig_nxt = c_dig_tens;
        end
        if (w_blank) begin
            w_seg_nxt = c_seg_blank;
            w_dig_nxt = c_dig_off;
        end
    end

    // Outputs only change one clock after a tick, so control inputs never act mid-digit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg <= c_seg_blank;
            r_dig <= c_dig_off;
        end else if (r_upd) begin
            r_seg <= w_seg_nxt;
            r_dig <= w_dig_nxt;
        end
    end

    assign {a, b, c, d, e, f, g} = r_seg;
    assign {D1, D0}              = r_dig;

endmodule
`default_nettype wire
